lsu_mem_initiator: RTL and testbench

Pipeline-side initiator for the data memory port. Accepts one load/store request at a time from the CPU MEM stage over a valid/ready handshake. Encodes RISC-V funct3 into the 4-bit sign_mask, sequences the memory's single-cycle read path and stall-based write path, and returns load data or a completion/error response over a valid/ready handshake. Sits between the MEM stage and the data memory block; its stall output replaces direct use of the memory's clk_stall.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_mask_encode.sv | 49 ++++
 rtl/lsu_mem_initiator.sv | 159 +++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 codes, memory sign_mask constants and initiator state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // bit3 sign-extend, bit2 word, bit1 half, bit0 byte
    localparam logic [3:0] MASK_LB  = 4'b1001;
    localparam logic [3:0] MASK_LBU = 4'b0001;
    localparam logic [3:0] MASK_LH  = 4'b1011;
    localparam logic [3:0] MASK_LHU = 4'b0011;
    localparam logic [3:0] MASK_LW  = 4'b0111;
    localparam logic [3:0] MASK_SB  = 4'b0001;
    localparam logic [3:0] MASK_SH  = 4'b0011;
    localparam logic [3:0] MASK_SW  = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_WSTALL  = 3'd3,
        S_RESP    = 3'd4
    } state_e;

endpackage

// File: rtl/lsu_mask_encode.sv
// Combinational funct3 -> sign_mask decode with alignment and legality flags.
// Zero latency; no handshake.
module lsu_mask_encode
    import lsu_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       is_store_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] sign_mask_o,
    output logic       misaligned_o,
    output logic       illegal_o,
    output logic [1:0] aligned_addr_lo_o
);

    always_comb begin
        sign_mask_o       = 4'b0000;
        misaligned_o      = 1'b0;
        illegal_o         = 1'b0;
        aligned_addr_lo_o = addr_lo_i;
        case (funct3_i)
            F3_B: sign_mask_o = is_store_i ? MASK_SB : MASK_LB;
            F3_H: begin
                sign_mask_o       = is_store_i ? MASK_SH : MASK_LH;
                misaligned_o      = addr_lo_i[0];
                aligned_addr_lo_o = {addr_lo_i[1], 1'b0};
            end
            F3_W: begin
                sign_mask_o       = is_store_i ? MASK_SW : MASK_LW;
                misaligned_o      = |addr_lo_i;
                aligned_addr_lo_o = 2'b00;
            end
            F3_BU: begin
                if (is_store_i) illegal_o = 1'b1;
                else            sign_mask_o = MASK_LBU;
            end
            F3_HU: begin
                if (is_store_i) begin
                    illegal_o = 1'b1;
                end else begin
                    sign_mask_o       = MASK_LHU;
                    misaligned_o      = addr_lo_i[0];
                    aligned_addr_lo_o = {addr_lo_i[1], 1'b0};
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// MEM-stage initiator for the data memory; LSU_MISALIGN_TRAP_EN makes misaligned half/word an error.
// Accept->resp_valid: load 3, store >=4, error 1; req_ready only in IDLE, response held until resp_ready.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int STALL_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [3:0]            mem_sign_mask,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_stall,
    output logic                  busy
);

    localparam int CW = $clog2(STALL_TIMEOUT + 1);

    state_e                state_q, state_d;
    logic                  is_store_q, is_store_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            mask_q, mask_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [3:0]            enc_mask;
    logic                  enc_misaligned;
    logic                  enc_illegal;
    logic [1:0]            enc_addr_lo;
    logic                  req_err;
    logic [ADDR_WIDTH-1:0] req_addr_eff;

    lsu_mask_encode u_mask_encode (
        .funct3_i          (req_funct3),
        .is_store_i        (req_is_store),
        .addr_lo_i         (req_addr[1:0]),
        .sign_mask_o       (enc_mask),
        .misaligned_o      (enc_misaligned),
        .illegal_o         (enc_illegal),
        .aligned_addr_lo_o (enc_addr_lo)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic unused_addr_lo;
    assign unused_addr_lo = ^enc_addr_lo;
    assign req_err        = enc_illegal | enc_misaligned;
    assign req_addr_eff   = req_addr;
`else
    // Misaligned half/word accesses are silently rounded down to their natural boundary.
    logic unused_misaligned;
    assign unused_misaligned = enc_misaligned;
    assign req_err           = enc_illegal;
    assign req_addr_eff      = {req_addr[ADDR_WIDTH-1:2], enc_addr_lo};
`endif

    always_comb begin
        state_d       = state_q;
        is_store_d    = is_store_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        mask_d        = mask_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_sign_mask = '0;

        if (state_q inside {S_ISSUE, S_CAPTURE, S_WSTALL}) begin
            mem_addr      = 32'(addr_q);
            mem_sign_mask = mask_q;
            mem_wdata     = is_store_q ? wdata_q : '0;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    is_store_d = req_is_store;
                    addr_d     = req_addr_eff;
                    wdata_d    = req_wdata;
                    mask_d     = enc_mask;
                    rdata_d    = '0;
                    cnt_d      = '0;
                    err_d      = req_err;
                    state_d    = req_err ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_read  = ~is_store_q;
                mem_write = is_store_q;
                state_d   = is_store_q ? S_WSTALL : S_CAPTURE;
            end
            S_CAPTURE: begin
                rdata_d = mem_rdata;
                state_d = S_RESP;
            end
            S_WSTALL: begin
                cnt_d = cnt_q + CW'(1);
                if (!mem_stall) begin
                    state_d = S_RESP;
                end else if (cnt_q == CW'(STALL_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized bench for lsu_mem_initiator: byte-array memory with programmable write stall,
// response expectations from a byte-level reference of RV32I load/store semantics.
module tb_lsu_mem_initiator;

    localparam int AW = 32;
    localparam int TO = 15;

    logic        clk, reset;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_stall, busy;
    logic [3:0]  mem_sign_mask;

    lsu_mem_initiator #(.ADDR_WIDTH(AW), .STALL_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_sign_mask(mem_sign_mask),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            16: return 8'hEF;
            17: return 8'hBE;
            18: return 8'hAD;
            19: return 8'hDE;
            default: return 8'(i * 37 + 11);
        endcase
    endfunction

    // ---------------- memory environment ----------------
    logic [7:0]  dev_mem [256];
    logic [31:0] rd_reg;
    int          stall_len;
    int          stall_cnt;
    logic        preload;

    function automatic logic [31:0] env_read(input logic [7:0] a, input logic [3:0] m);
        logic [31:0] w;
        w = {dev_mem[8'(a + 8'd3)], dev_mem[8'(a + 8'd2)], dev_mem[8'(a + 8'd1)], dev_mem[a]};
        if (m[2])      return w;
        else if (m[1]) return m[3] ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
        else           return m[3] ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= init_byte(i);
        end else if (mem_write) begin
            for (int k = 0; k < 4; k++)
                if (k == 0 || (k == 1 && mem_sign_mask[1]) || mem_sign_mask[2])
                    dev_mem[8'(mem_addr[7:0] + 8'(k))] <= mem_wdata[8*k +: 8];
        end
        if (reset)                 stall_cnt <= 0;
        else if (mem_write)        stall_cnt <= stall_len;
        else if (stall_cnt != 0)   stall_cnt <= stall_cnt - 1;
        if (mem_read) rd_reg <= env_read(mem_addr[7:0], mem_sign_mask);
    end
    assign mem_stall = (stall_cnt != 0);
    assign mem_rdata = rd_reg;

    // ---------------- bus monitor (monotonic counters) ----------------
    int          mon_rd = 0, mon_wr = 0, mon_busy = 0, mon_both = 0, mon_addr_bad = 0;
    logic        mon_seen = 1'b0;
    logic [31:0] mon_pulse_addr = '0;

    always @(negedge clk) begin
        if (mem_read)  mon_rd++;
        if (mem_write) mon_wr++;
        if (busy)      mon_busy++;
        if (mem_read && mem_write) mon_both++;
        if (!busy) mon_seen = 1'b0;
        if (mem_read || mem_write) begin
            mon_seen       = 1'b1;
            mon_pulse_addr = mem_addr;
        end else if (busy && !resp_valid && mon_seen && mem_addr !== mon_pulse_addr) begin
            mon_addr_bad++;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [256];

    function automatic int acc_bytes(input logic [2:0] f3);
        if (f3 == 3'd2) return 4;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] ea);
        int n;
        logic [31:0] v;
        n = acc_bytes(f3);
        v = 0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[8'(ea[7:0] + 8'(k))]) << (8 * k));
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] ea, input logic [31:0] wd);
        for (int k = 0; k < acc_bytes(f3); k++) ref_mem[8'(ea[7:0] + 8'(k))] = wd[8*k +: 8];
    endtask

    task automatic do_req(input string tag, input bit is_st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int stall, input int hold);
        bit          illegal, mis, err0, tmo, exp_err;
        logic [31:0] ea, exp_rd;
        int          exp_lat, lat, rd0, wr0, bz0, bo0, ab0;

        illegal = (f3 == 3'd3) || (f3 >= 3'd6) || (is_st && (f3 == 3'd4 || f3 == 3'd5));
        mis     = (acc_bytes(f3) == 2 && addr[0]) || (acc_bytes(f3) == 4 && addr[1:0] != 0);
`ifdef LSU_MISALIGN_TRAP_EN
        err0 = illegal || mis;
`else
        err0 = illegal;
`endif
        ea = addr;
        if (acc_bytes(f3) == 2) ea[0] = 1'b0;
        if (acc_bytes(f3) == 4) ea[1:0] = 2'b00;
        tmo     = is_st && !err0 && stall >= TO;
        exp_err = err0 || tmo;
        exp_rd  = (!err0 && !is_st) ? ref_load(f3, ea) : 32'h0;
        if (err0)        exp_lat = 1;
        else if (!is_st) exp_lat = 3;
        else if (tmo)    exp_lat = 2 + TO;
        else             exp_lat = 3 + stall;

        @(negedge clk);
        stall_len    = stall;
        req_valid    = 1'b1;
        req_is_store = is_st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wd;
        check_val({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        rd0 = mon_rd; wr0 = mon_wr; bz0 = mon_busy; bo0 = mon_both; ab0 = mon_addr_bad;
        lat = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
        end while (!resp_valid && lat < 40);
        check_val({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, ".err"}, 32'(resp_err), 32'(exp_err));
        check_val({tag, ".rdata"}, resp_rdata, exp_rd);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
            check_val({tag, ".hold_rdata"}, resp_rdata, exp_rd);
            check_val({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_val({tag, ".post_valid"}, 32'(resp_valid), 32'd0);
        check_val({tag, ".post_ready"}, 32'(req_ready), 32'd1);
        check_val({tag, ".rd_pulses"}, 32'(mon_rd - rd0), 32'((!err0 && !is_st) ? 1 : 0));
        check_val({tag, ".wr_pulses"}, 32'(mon_wr - wr0), 32'((!err0 && is_st) ? 1 : 0));
        check_val({tag, ".busy_cycles"}, 32'(mon_busy - bz0), 32'(exp_lat + hold));
        check_val({tag, ".both_high"}, 32'(mon_both - bo0), 32'd0);
        check_val({tag, ".addr_stable"}, 32'(mon_addr_bad - ab0), 32'd0);
        if (!err0) check_val({tag, ".mem_addr"}, mon_pulse_addr, ea);
        if (is_st && !err0) ref_store(f3, ea, wd);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] w;
        int          stalls [7] = '{1, 1, 2, 3, 14, 15, 16};

        req_valid = 0; req_is_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        resp_ready = 0; stall_len = 1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        reset = 1; preload = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0; preload = 0;

        check_val("rst.req_ready", 32'(req_ready), 32'd1);
        check_val("rst.resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst.busy", 32'(busy), 32'd0);
        check_val("rst.mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check_val("rst.mem_addr", mem_addr, 32'd0);
        check_val("rst.mem_mask", 32'(mem_sign_mask), 32'd0);
        check_val("rst.resp", {resp_rdata[30:0], resp_err}, 32'd0);

        do_req("lb13", 0, 3'd0, 32'h13, 0, 1, 0);
        check_val("lb13.const", resp_rdata, 32'hFFFFFFDE);
        do_req("lbu13", 0, 3'd4, 32'h13, 0, 1, 0);
        check_val("lbu13.const", resp_rdata, 32'h000000DE);
        do_req("sh12", 1, 3'd1, 32'h12, 32'h0000_1234, 1, 0);
        do_req("lw10", 0, 3'd2, 32'h10, 0, 1, 0);
        check_val("lw10.const", resp_rdata, 32'h1234BEEF);
        do_req("lw11", 0, 3'd2, 32'h11, 0, 1, 0);
        do_req("sw_tmo", 1, 3'd2, 32'h40, 32'hCAFEF00D, 100, 0);
        do_req("lw_after_tmo", 0, 3'd2, 32'h40, 0, 1, 0);
        do_req("lh_hold", 0, 3'd1, 32'h10, 0, 1, 5);
        do_req("ill_f3", 0, 3'd3, 32'h20, 0, 1, 0);
        do_req("sbu_ill", 1, 3'd4, 32'h20, 32'h55, 1, 0);
        do_req("sw_to14", 1, 3'd2, 32'h44, 32'h01020304, 14, 0);
        do_req("sw_to15", 1, 3'd2, 32'h48, 32'h0A0B0C0D, 15, 0);

        // Reset while the store sits in WSTALL; the memory write already happened.
        @(negedge clk);
        stall_len = 100; req_valid = 1; req_is_store = 1; req_funct3 = 3'd2;
        req_addr = 32'h20; req_wdata = 32'h89ABCDEF;
        @(negedge clk); req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check_val("rstw.busy_before", 32'(busy), 32'd1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check_val("rstw.busy", 32'(busy), 32'd0);
        check_val("rstw.req_ready", 32'(req_ready), 32'd1);
        check_val("rstw.resp_valid", 32'(resp_valid), 32'd0);
        check_val("rstw.mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check_val("rstw.mem_addr", mem_addr, 32'd0);
        check_val("rstw.mem_wdata", mem_wdata, 32'd0);
        ref_store(3'd2, 32'h20, 32'h89ABCDEF);
        do_req("lw_after_rst", 0, 3'd2, 32'h20, 0, 1, 0);

        for (int t = 0; t < 150; t++) begin
            f3 = 3'($urandom_range(0, 9) < 8 ? $urandom_range(0, 2) + ($urandom_range(0, 1) ? 0 : 0) : $urandom_range(3, 7));
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(4, 5));
            w = $urandom;
            do_req("rnd", $urandom_range(0, 1) == 1, f3, 32'($urandom_range(0, 255)), w,
                   stalls[$urandom_range(0, 6)], $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
